aes128_encrypt_iter: RTL
========================

Name: aes128_encrypt_iter

Overview:
- Iterative AES-128 encryption engine: one round per clock, with on-the-fly key expansion.
- Instantiates the existing subBytes, shift_rows, mix_columns and encrypt_final_round stages.
- Applies AddRoundKey after every round, so it consumes what the final-round stage produces.
- Feeds the CTR keystream XOR behind the AXI4-Lite register file; valid/ready handshake on both sides.

Parameters:
- NR, 10, number of rounds (fixed for AES-128; any other value is illegal and rejected at elaboration)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- key  input  128  cipher key, byte 0 in [127:120]; sampled only on input handshake
- block_in  input  128  plaintext/counter block, same byte order
- in_valid  input  1  block_in/key valid
- in_ready  output  1  engine can accept a block
- block_out  output  128  ciphertext/keystream block
- out_valid  output  1  block_out valid
- out_ready  input  1  consumer accepts block_out

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=0 during reset then 1 in IDLE; out_valid=0, block_out=0, round counter=0, internal state and round-key registers=0.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T: state_reg<=block_in^key, rk_reg<=key, rnd<=1, go to RUN.
- RUN:
  - in_ready=0; each edge computes next_rk=key_step(rk_reg, RCON[rnd]).
  - rnd 1..9: state_reg<=MixColumns(ShiftRows(SubBytes(state_reg)))^next_rk, rk_reg<=next_rk, rnd<=rnd+1.
  - rnd 10: block_out<=encrypt_final_round(state_reg)^next_rk, out_valid<=1, go to DONE.
- Latency: out_valid rises after edge T+10, i.e. 10 cycles after the accept edge.
- DONE:
  - block_out and out_valid held stable until out_valid&&out_ready.
  - On that edge: out_valid<=0, go to IDLE. block_out keeps its last value (not cleared).
- No same-cycle output/input overlap: in_ready stays 0 in DONE even when out_ready=1. Throughput is 1 block per 12 cycles with an always-ready consumer.
- key and block_in changes during RUN/DONE are ignored; key is re-latched per block, so key changes between blocks need no flush.
- in_valid while not ready: no effect; the producer must hold it.
- out_ready while out_valid=0: ignored.
- rst_n asserted mid-RUN or mid-DONE: operation aborted, all outputs to reset values immediately, no partial block emitted.
- RCON sequence: 01,02,04,08,10,20,40,80,1b,36 for rnd 1..10.
- key_step:
  - w3' = SubWord(RotWord(w3)) ^ {RCON,24'h0}
  - w0n = w0^w3'; w1n = w1^w0n; w2n = w2^w1n; w3n = w3^w2n
  - w0 = rk[127:96].
- rnd counter is 4 bits; values 0 and 11..15 are unreachable; if reached, the FSM returns to IDLE.

Decomposition:
- Shared include file aes_defs.vh holds:
  - state encodings (IDLE/RUN/DONE)
  - the RCON table as a function indexed 1..10
  - NR=10 and block width 128.
- One new sub-module, aes_key_step: combinational, inputs rk[127:0] and rcon[7:0], output next_rk[127:0]. It uses four S-box lookups from the existing sbox used by subBytes.
- Datapath reuses subBytes, shift_rows, mix_columns and encrypt_final_round unchanged.

Test Plan:
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff -> block_out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, block 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. Also check the internal round-1 key a0fafe1788542cb123a339392a6c7605.
- All-zero key and block -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Backpressure:
  - Hold out_ready=0 for 20 cycles after out_valid; block_out stable, in_ready=0 throughout.
  - Then raise out_ready for 1 cycle; out_valid drops next cycle and in_ready=1.
- Back-to-back with in_valid constant high and out_ready=1, App. B then App. C.1 vectors (key changed between) -> both correct, second accept exactly 12 cycles after the first.
- Reset asserted at rnd=5 of an App. B run -> out_valid=0 and block_out=0 at once. After release a new App. C.1 run gives the correct result; no stale output appears.

Source files
------------

// File: rtl/aes128_encrypt_iter_pkg.sv
// Shared AES-128 definitions: FSM encodings, round constants, S-box and the
// per-round state transforms used by the iterative engine.
package aes128_encrypt_iter_pkg;

    localparam int NR_AES = 10;
    localparam int BLK_W  = 128;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Index 0 and 11..15 never occur in a legal run; they yield zero.
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [BLK_W-1:0] sub_bytes(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return r;
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                r[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c+rw)%4)+rw) -: 8];
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        logic [7:0]       a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] encrypt_final_round(input logic [BLK_W-1:0] s);
        return shift_rows(sub_bytes(s));
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: derives the next round key from the current one.
module aes_key_step
    import aes128_encrypt_iter_pkg::*;
(
    input  logic [127:0] rk,
    input  logic [7:0]   rcon,
    output logic [127:0] next_rk
);

    logic [31:0] w_rot;
    logic [31:0] w_t;
    logic [31:0] w_0n, w_1n, w_2n, w_3n;

    assign w_rot = {rk[23:0], rk[31:24]};
    assign w_t   = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])}
                   ^ {rcon, 24'h0};

    assign w_0n = rk[127:96] ^ w_t;
    assign w_1n = rk[95:64]  ^ w_0n;
    assign w_2n = rk[63:32]  ^ w_1n;
    assign w_3n = rk[31:0]   ^ w_2n;

    assign next_rk = {w_0n, w_1n, w_2n, w_3n};

endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion,
// valid/ready handshake on input and output.
module aes128_encrypt_iter
    import aes128_encrypt_iter_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key,
    input  logic [127:0] block_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] block_out,
    output logic         out_valid,
    input  logic         out_ready
);

    if (NR != NR_AES) begin : g_bad_nr
        $error("aes128_encrypt_iter: NR must be 10 for AES-128");
    end

    localparam logic [3:0] LAST_RND = 4'(NR);

    logic [1:0]   r_state;
    logic [3:0]   r_rnd;
    logic [127:0] r_blk;
    logic [127:0] r_rk;
    logic [127:0] r_block_out;
    logic         r_out_valid;
    logic [127:0] w_next_rk;

    aes_key_step u_key_step (
        .rk      (r_rk),
        .rcon    (rcon(r_rnd)),
        .next_rk (w_next_rk)
    );

    // Held low while reset is asserted so no handshake can start during reset.
    assign in_ready  = rst_n && (r_state == S_IDLE);
    assign block_out = r_block_out;
    assign out_valid = r_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rnd       <= 4'd0;
            r_blk       <= '0;
            r_rk        <= '0;
            r_block_out <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_blk   <= block_in ^ key;
                        r_rk    <= key;
                        r_rnd   <= 4'd1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_rnd >= 4'd1 && r_rnd < LAST_RND) begin
                        r_blk <= mix_columns(shift_rows(sub_bytes(r_blk))) ^ w_next_rk;
                        r_rk  <= w_next_rk;
                        r_rnd <= r_rnd + 4'd1;
                    end else if (r_rnd == LAST_RND) begin
                        r_block_out <= encrypt_final_round(r_blk) ^ w_next_rk;
                        r_out_valid <= 1'b1;
                        r_rnd       <= 4'd0;
                        r_state     <= S_DONE;
                    end else begin
                        r_rnd   <= 4'd0;
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    // block_out deliberately retains the last result after handoff.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rnd       <= 4'd0;
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
